// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller with divider handshake and dmem timeout
module pipe_stall_ctrl #(
    parameter int DMEM_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_keep_pc,
    input  logic             hz_stall_IF_ID,
    input  logic             hz_flush_IF_ID,
    input  logic             hz_flush_ID_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ack_MEM,
    input  logic             div_req_EX,
    input  logic             div_done,
    output logic             div_start,
    output logic             div_ack,
    output logic             keep_pc,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             dmem_timeout
);

    localparam int TW = (DMEM_TIMEOUT < 1) ? 1 : $clog2(DMEM_TIMEOUT + 1);
    localparam bit TMO_EN = (DMEM_TIMEOUT > 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             dmem_timeout_q, dmem_timeout_d;

    logic mem_wait, tmo_hit;
    logic mem_stall, div_stall, div_ack_w, div_start_w;

    assign mem_wait = dmem_req_MEM & ~dmem_ack_MEM;
    assign tmo_hit  = TMO_EN & mem_wait & (tmo_cnt_q == TMO_LAST);

    always_comb begin
        mem_stall   = mem_wait | (state_q == ERR);
        div_ack_w   = (state_q == DIV_BUSY) & div_done & ~mem_stall;
        div_stall   = ((state_q == RUN) & div_req_EX) | ((state_q == DIV_BUSY) & ~div_ack_w);
        div_start_w = (state_q == RUN) & div_req_EX & ~mem_stall;
    end

    // Every control output is forced low during the reset cycle.
    always_comb begin
        div_start    = div_start_w & ~rst;
        div_ack      = div_ack_w & ~rst;
        keep_pc      = (mem_stall | div_stall | hz_keep_pc) & ~rst;
        stall_IF_ID  = (mem_stall | div_stall | hz_stall_IF_ID) & ~rst;
        stall_ID_EX  = (mem_stall | div_stall) & ~rst;
        stall_EX_MEM = mem_stall & ~rst;
        flush_IF_ID  = hz_flush_IF_ID & ~mem_stall & ~div_stall & ~rst;
        flush_ID_EX  = hz_flush_ID_EX & ~mem_stall & ~div_stall & ~rst;
        flush_EX_MEM = div_stall & ~mem_stall & ~rst;
        flush_MEM_WB = mem_stall & ~rst;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (div_start_w) state_d = DIV_BUSY;
            DIV_BUSY: if (div_ack_w)   state_d = RUN;
            ERR:      state_d = ERR;
            default:  state_d = RUN;
        endcase
        if (tmo_hit) state_d = ERR;
    end

    always_comb begin
        tmo_cnt_d = '0;
        if (TMO_EN && mem_wait) begin
            tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
        end
        stall_cnt_d = stall_cnt_q;
        if (keep_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        dmem_timeout_d = dmem_timeout_q | tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            tmo_cnt_q      <= '0;
            stall_cnt_q    <= '0;
            dmem_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_cnt_q      <= tmo_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            dmem_timeout_q <= dmem_timeout_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign dmem_timeout = dmem_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hz_keep_pc = 1'b0, hz_stall_IF_ID = 1'b0, hz_flush_IF_ID = 1'b0, hz_flush_ID_EX = 1'b0;
    logic       dmem_req_MEM = 1'b0, dmem_ack_MEM = 1'b0, div_req_EX = 1'b0, div_done = 1'b0;
    logic       div_start, div_ack, keep_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
    logic       flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
    logic [3:0] stall_cycles;
    logic       dmem_timeout;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    pipe_stall_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .hz_keep_pc(hz_keep_pc), .hz_stall_IF_ID(hz_stall_IF_ID),
        .hz_flush_IF_ID(hz_flush_IF_ID), .hz_flush_ID_EX(hz_flush_ID_EX),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ack_MEM(dmem_ack_MEM),
        .div_req_EX(div_req_EX), .div_done(div_done),
        .div_start(div_start), .div_ack(div_ack), .keep_pc(keep_pc),
        .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
        .stall_cycles(stall_cycles), .dmem_timeout(dmem_timeout)
    );

    always #5 clk = ~clk;

    // Inputs:  {hz_keep_pc, hz_stall, hz_flush_IF_ID, hz_flush_ID_EX, dmem_req, dmem_ack, div_req, div_done}
    // Outputs: {div_start, div_ack, keep_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    //           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB}
    localparam logic [9:0] O_IDLE  = 10'b00_0000_00_00;
    localparam logic [9:0] O_DSTRT = 10'b10_1110_00_10;
    localparam logic [9:0] O_DBUSY = 10'b00_1110_00_10;
    localparam logic [9:0] O_DACK  = 10'b01_0000_00_00;
    localparam logic [9:0] O_MEMW  = 10'b00_1111_00_01;
    localparam logic [9:0] O_FLUSH = 10'b00_0000_11_00;
    localparam logic [9:0] O_HZKP  = 10'b00_1100_00_00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [7:0] in, input logic [9:0] exp);
        logic [9:0] got;
        logic [9:0] e;
        @(posedge clk);
        #1;
        rst = r;
        {hz_keep_pc, hz_stall_IF_ID, hz_flush_IF_ID, hz_flush_ID_EX,
         dmem_req_MEM, dmem_ack_MEM, div_req_EX, div_done} = in;
        exp_q.push_back(exp);
        #3;
        got = {div_start, div_ack, keep_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB};
        e = exp_q.pop_front();
        check_eq(tag, {22'd0, got}, {22'd0, e});
    endtask

    initial begin
        // Reset with active requests: controls must stay low.
        step("rst_gate", 1'b1, 8'b0000_1010, O_IDLE);
        step("idle", 1'b0, 8'h00, O_IDLE);
        check_eq("rst_cnt", {28'd0, stall_cycles}, 32'd0);
        check_eq("rst_tmo", {31'd0, dmem_timeout}, 32'd0);

        // T1: divide with done at c5, then back-to-back divide.
        step("t1_c0", 1'b0, 8'b0000_0010, O_DSTRT);
        for (int i = 1; i < 5; i++) step("t1_busy", 1'b0, 8'b0000_0010, O_DBUSY);
        step("t1_ack", 1'b0, 8'b0000_0011, O_DACK);
        step("t1_b2b", 1'b0, 8'b0000_0010, O_DSTRT);
        step("t1_ack2", 1'b0, 8'b0000_0011, O_DACK);
        step("t1_idle", 1'b0, 8'h00, O_IDLE);
        check_eq("t1_cnt", {28'd0, stall_cycles}, 32'd6);

        // T2: dmem wait c0-c2, ack at c3.
        step("t2_rst", 1'b1, 8'h00, O_IDLE);
        for (int i = 0; i < 3; i++) step("t2_wait", 1'b0, 8'b0000_1000, O_MEMW);
        step("t2_ack", 1'b0, 8'b0000_1100, O_IDLE);
        step("t2_idle", 1'b0, 8'h00, O_IDLE);
        check_eq("t2_cnt", {28'd0, stall_cycles}, 32'd3);

        // T3: divide overlapped by dmem wait c4-c6; ack deferred to c6.
        step("t3_rst", 1'b1, 8'h00, O_IDLE);
        step("t3_c0", 1'b0, 8'b0000_0010, O_DSTRT);
        for (int i = 1; i < 4; i++) step("t3_busy", 1'b0, 8'b0000_0010, O_DBUSY);
        step("t3_c4", 1'b0, 8'b0000_1010, O_MEMW);
        step("t3_c5", 1'b0, 8'b0000_1011, O_MEMW);
        step("t3_c6", 1'b0, 8'b0000_1111, O_DACK);
        step("t3_idle", 1'b0, 8'h00, O_IDLE);
        check_eq("t3_tmo", {31'd0, dmem_timeout}, 32'd0);

        // T4: four un-acked cycles trip the timeout; ERR stalls until reset.
        step("t4_rst", 1'b1, 8'h00, O_IDLE);
        for (int i = 0; i < 4; i++) begin
            step("t4_wait", 1'b0, 8'b0000_1000, O_MEMW);
            check_eq("t4_tmo_lo", {31'd0, dmem_timeout}, 32'd0);
        end
        step("t4_err", 1'b0, 8'h00, O_MEMW);
        check_eq("t4_tmo_hi", {31'd0, dmem_timeout}, 32'd1);
        step("t4_err_div", 1'b0, 8'b0000_0010, O_MEMW);
        step("t4_err_flush", 1'b0, 8'b0011_0000, O_MEMW);
        check_eq("t4_sticky", {31'd0, dmem_timeout}, 32'd1);
        step("t4_rst2", 1'b1, 8'h00, O_IDLE);
        step("t4_clear", 1'b0, 8'h00, O_IDLE);
        check_eq("t4_tmo_clr", {31'd0, dmem_timeout}, 32'd0);

        // T5: hazard flushes pass, masked by a dmem wait, and reassert after.
        step("t5_flush", 1'b0, 8'b0011_0000, O_FLUSH);
        step("t5_masked", 1'b0, 8'b0011_1000, O_MEMW);
        step("t5_reflush", 1'b0, 8'b0011_1100, O_FLUSH);
        step("t5_hzkp", 1'b0, 8'b1100_0000, O_HZKP);
        step("t5_divmask", 1'b0, 8'b0011_0010, O_DSTRT);
        step("t5_divack", 1'b0, 8'b0011_0011, O_DACK | O_FLUSH);

        // T6: stall counter saturates at 15; reset in DIV_BUSY never acks.
        step("t6_rst", 1'b1, 8'h00, O_IDLE);
        for (int i = 0; i < 20; i++) step("t6_hz", 1'b0, 8'b1000_0000, 10'b00_1000_00_00);
        step("t6_idle", 1'b0, 8'h00, O_IDLE);
        check_eq("t6_sat", {28'd0, stall_cycles}, 32'd15);
        step("t6_start", 1'b0, 8'b0000_0010, O_DSTRT);
        step("t6_busy", 1'b0, 8'b0000_0010, O_DBUSY);
        step("t6_rst_busy", 1'b1, 8'b0000_0011, O_IDLE);
        step("t6_done_ign", 1'b0, 8'b0000_0001, O_IDLE);
        step("t6_restart", 1'b0, 8'b0000_0010, O_DSTRT);
        check_eq("t6_queue", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
